// File: rtl/regfile_dump.sv
// Debug read-out engine for the register file.
// A start pulse walks addresses 0..NREGS-1 through the regfile's asynchronous
// read port and streams each value over a valid/ready output, flagging the
// last beat. The regfile write port is snooped so that a pending beat always
// matches the regfile contents at the moment it is accepted.
//
// Handshake: a beat transfers on a rising edge where out_valid and out_ready
// are both high. Once out_valid rises it stays high, and out_data, out_addr
// and out_last stay stable (apart from snooped write updates to the same
// register), until that transfer happens. out_valid never depends on
// out_ready.
module regfile_dump #(
   parameter int NREGS = 32,
   parameter int AW    = 5,
   parameter int DW    = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic [AW-1:0] rf_ra,
   input  logic [DW-1:0] rf_rd,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [AW-1:0] out_addr,
   output logic          out_last,
   output logic          busy,
   output logic          done,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_SEND = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Highest register index; it reads as zero, so writes to it are never
   // captured into the beat buffer.
   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [DW-1:0] buf_q, buf_d;

   logic          at_last;
   logic          snoop_hit;

   assign at_last   = (ptr_q == LAST);
   assign snoop_hit = wr_en && (wr_addr == ptr_q) && !at_last;
   assign dbg_state = state_q;

   // State, pointer and capture buffer registers; reset abandons any dump.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         buf_q   <= buf_d;
      end
   end

   // Next-state logic and all outputs, decoded from the current state.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      buf_d     = buf_q;
      rf_ra     = '0;
      out_valid = 1'b0;
      out_data  = '0;
      out_addr  = '0;
      out_last  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               ptr_d   = '0;
               state_d = S_LOAD;
            end
         end

         S_LOAD: begin
            busy  = 1'b1;
            rf_ra = ptr_q;
            // A write landing on this register at the same edge wins over
            // the stale value the read port is still showing.
            buf_d   = snoop_hit ? wr_data : rf_rd;
            state_d = S_SEND;
         end

         S_SEND: begin
            busy      = 1'b1;
            rf_ra     = ptr_q;
            out_valid = 1'b1;
            out_data  = buf_q;
            out_addr  = ptr_q;
            out_last  = at_last;
            if (out_ready) begin
               // The accepted beat carries the pre-edge value; a coincident
               // write to this register is not folded in.
               if (at_last) begin
                  state_d = S_DONE;
               end else begin
                  ptr_d   = ptr_q + AW'(1);
                  state_d = S_LOAD;
               end
            end else if (snoop_hit) begin
               // Keep the stalled beat in step with the regfile.
               buf_d = wr_data;
            end
         end

         S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a behavioural regfile, a stimulus process that
// pushes the hand-computed beat sequence into exp_q, and a monitor that pops
// and compares on every accepted beat.
module tb_regfile_dump;

   localparam int W = 70; // {last, addr[4:0], data[63:0]}

   logic        clk;
   logic        reset;
   logic        start;
   logic [4:0]  rf_ra;
   logic [63:0] rf_rd;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [4:0]  out_addr;
   logic        out_last;
   logic        busy;
   logic        done;
   logic [1:0]  dbg_state;

   logic        rf_init;
   logic [63:0] rf_mem [32];

   logic [W-1:0] exp_q[$];

   int n_checks;
   int n_pass;
   int cyc;
   int start_cyc;

   regfile_dump #(.NREGS(32), .AW(5), .DW(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .rf_ra     (rf_ra),
      .rf_rd     (rf_rd),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_addr  (out_addr),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset / regfile model ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Regfile: register i holds i after init; X31 reads zero, ignores writes.
   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= 64'(i);
      end else if (wr_en && wr_addr != 5'd31) begin
         rf_mem[wr_addr] <= wr_data;
      end
   end
   assign rf_rd = (rf_ra == 5'd31) ? 64'd0 : rf_mem[rf_ra];

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
   endtask

   // Monitor: every accepted beat must match the head of the expected queue.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL beat_unexpected: got addr %0d data %0h, expected no beat", out_addr, out_data);
         end else begin
            check("beat", {out_last, out_addr, out_data}, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beat(input int addr, input logic [63:0] data);
      logic [4:0] a;
      a = 5'(addr);
      exp_q.push_back({(addr == 31), a, data});
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start_cyc = cyc;
      start = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, W'(out_valid), W'(0));
      check({tag, "_last"},  W'(out_last),  W'(0));
      check({tag, "_busy"},  W'(busy),      W'(0));
      check({tag, "_done"},  W'(done),      W'(0));
      check({tag, "_addr"},  W'(out_addr),  W'(0));
      check({tag, "_data"},  W'(out_data),  W'(0));
      check({tag, "_ra"},    W'(rf_ra),     W'(0));
   endtask

   // Drive ready/write/start cycle by cycle until done.
   // mode 1: ready always high
   // mode 2: stall addr 7 for 5 cycles, start at beat 10, stalled write DEAD to 12
   // mode 3: write BEEF to 12 on its handshake, write 0x55 to 31 while stalled
   // mode 4: reset asserted while beat 20 is presented
   task automatic run_dump(input int mode);
      int  guard;
      int  hold7;
      int  ph12;
      int  ph31;
      bit  seen10;
      bit  aborted;
      guard   = 0;
      hold7   = 0;
      ph12    = 0;
      ph31    = 0;
      seen10  = 0;
      aborted = 0;
      while (!done && !aborted && guard < 400) begin
         out_ready = 1'b1;
         wr_en     = 1'b0;
         start     = 1'b0;
         if (out_valid) begin
            if (mode == 2 && out_addr == 5'd7 && hold7 < 5) begin
               check("stall7_addr", W'(out_addr), W'(7));
               check("stall7_data", W'(out_data), W'(7));
               out_ready = 1'b0;
               hold7++;
            end
            if (mode == 2 && out_addr == 5'd10 && !seen10) begin
               start  = 1'b1;
               seen10 = 1'b1;
            end
            if (mode == 2 && out_addr == 5'd12) begin
               if (ph12 == 0) begin
                  out_ready = 1'b0;
                  wr_en = 1'b1; wr_addr = 5'd12; wr_data = 64'hDEAD;
                  ph12 = 1;
               end else if (ph12 == 1) begin
                  check("snoop12_data", W'(out_data), W'(64'hDEAD));
                  ph12 = 2;
               end
            end
            if (mode == 3 && out_addr == 5'd12 && ph12 == 0) begin
               wr_en = 1'b1; wr_addr = 5'd12; wr_data = 64'hBEEF;
               ph12 = 1;
            end
            if (mode == 3 && out_addr == 5'd31) begin
               if (ph31 == 0) begin
                  out_ready = 1'b0;
                  wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'h55;
                  ph31 = 1;
               end else if (ph31 == 1) begin
                  check("x31_data", W'(out_data), W'(0));
                  ph31 = 2;
               end
            end
            if (mode == 4 && out_addr == 5'd20) begin
               out_ready = 1'b0;
               reset = 1'b1;
               #1;
               check_all_zero("midreset");
               aborted = 1'b1;
            end
         end
         if (!aborted) begin
            step();
            guard++;
         end
      end
      start = 1'b0;
      wr_en = 1'b0;
      if (mode != 4) check("done_seen", W'(done), W'(1));
      else check("reset_reached", W'(aborted), W'(1));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks  = 0;
      n_pass    = 0;
      cyc       = 0;
      start_cyc = 0;
      reset     = 1'b1;
      start     = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      out_ready = 1'b0;
      rf_init   = 1'b1;
      step();
      step();
      rf_init = 1'b0;
      check_all_zero("reset");
      check("reset_state", W'(dbg_state), W'(0));
      reset = 1'b0;
      step();
      check_all_zero("idle");

      // Dump 1: ready held high, latency and done timing.
      for (int i = 0; i < 31; i++) push_beat(i, 64'(i));
      push_beat(31, 64'd0);
      out_ready = 1'b1;
      pulse_start();
      check("load_busy",  W'(busy),      W'(1));
      check("load_valid", W'(out_valid), W'(0));
      step();
      check("first_valid", W'(out_valid), W'(1));
      check("first_addr",  W'(out_addr),  W'(0));
      run_dump(1);
      check("done_cycle", W'(cyc - start_cyc), W'(64));
      step();
      check("done_pulse",  W'(done), W'(0));
      check("done_idle",   W'(busy), W'(0));
      check("dump1_drain", W'(exp_q.size()), W'(0));

      // Dump 2: stall on 7, ignored start at 10, stalled snoop on 12.
      for (int i = 0; i < 31; i++) push_beat(i, (i == 12) ? 64'hDEAD : 64'(i));
      push_beat(31, 64'd0);
      pulse_start();
      run_dump(2);
      step();
      check("dump2_drain", W'(exp_q.size()), W'(0));
      check("dump2_idle",  W'(busy), W'(0));

      // Restore register 12 while idle, then dump 3.
      wr_en = 1'b1; wr_addr = 5'd12; wr_data = 64'd12;
      step();
      wr_en = 1'b0;
      for (int i = 0; i < 31; i++) push_beat(i, 64'(i));
      push_beat(31, 64'd0);
      pulse_start();
      run_dump(3);
      step();
      check("dump3_drain", W'(exp_q.size()), W'(0));

      // Dump 4: reset while beat 20 is on offer; beats 0..19 delivered.
      for (int i = 0; i < 20; i++) push_beat(i, (i == 12) ? 64'hBEEF : 64'(i));
      pulse_start();
      run_dump(4);
      step();
      reset = 1'b0;
      check("dump4_drain", W'(exp_q.size()), W'(0));
      for (int k = 0; k < 3; k++) begin
         step();
         check("post_reset_valid", W'(out_valid), W'(0));
         check("post_reset_busy",  W'(busy),      W'(0));
      end

      // Dump 5: fresh start after reset restarts from address 0.
      for (int i = 0; i < 31; i++) push_beat(i, (i == 12) ? 64'hBEEF : 64'(i));
      push_beat(31, 64'd0);
      out_ready = 1'b1;
      pulse_start();
      step();
      check("restart_addr", W'(out_addr), W'(0));
      run_dump(1);
      step();
      check("dump5_drain", W'(exp_q.size()), W'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Watchdog: the whole run is a few thousand ns.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
